// File: rtl/template_pkg.sv
// rtl/template_pkg.sv - shared types and constants for the template arbiter
// Holds the arbiter state encoding, the requester-index width helper and the
// width of the datapath latency counter (LAT is at most 15).
package template_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int CNT_W = 4;

    // Width of a requester index; never less than one bit.
    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/template_arbiter_if.sv
// rtl/template_arbiter_if.sv - request/datapath/response bundle of the template arbiter
// Signals keep the arbiter-centric i_/o_ names.
//   slave  : arbiter side (drives o_*, receives i_*)
//   master : environment side (drives i_*, receives o_*)
interface template_arbiter_if
    import template_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = 8
);
    localparam int IDW = id_w(NREQ);

    logic [NREQ-1:0]    i_req_valid;
    logic [NREQ*DW-1:0] i_req_data;
    logic [NREQ-1:0]    o_req_ready;
    logic [DW-1:0]      o_dp_data;
    logic               o_dp_valid;
    logic [DW-1:0]      i_dp_data;
    logic               o_rsp_valid;
    logic [IDW-1:0]     o_rsp_id;
    logic [DW-1:0]      o_rsp_data;
    logic               i_rsp_ready;

    modport slave (
        input  i_req_valid, i_req_data, i_dp_data, i_rsp_ready,
        output o_req_ready, o_dp_data, o_dp_valid, o_rsp_valid, o_rsp_id, o_rsp_data
    );

    modport master (
        output i_req_valid, i_req_data, i_dp_data, i_rsp_ready,
        input  o_req_ready, o_dp_data, o_dp_valid, o_rsp_valid, o_rsp_id, o_rsp_data
    );

endinterface

// File: rtl/template_rr_pick.sv
// rtl/template_rr_pick.sv - combinational rotating-priority picker
// Ports:
//   valid : per-requester valid vector
//   ptr   : index given highest priority; scan goes upward modulo NREQ
//   grant : one-hot winner (zero when nothing is valid)
//   idx   : binary index of the winner
//   any   : at least one requester valid
module template_rr_pick
    import template_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = id_w(NREQ)
) (
    input  logic [NREQ-1:0] valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!any && valid[(int'(ptr) + i) % NREQ]) begin
                any = 1'b1;
                grant[(int'(ptr) + i) % NREQ] = 1'b1;
                idx = IDW'((int'(ptr) + i) % NREQ);
            end
        end
    end

endmodule

// File: rtl/template_arbiter.sv
// rtl/template_arbiter.sv - NREQ-way arbiter around a shared fixed-latency datapath
// Optional feature macro: TEMPLATE_ARB_FIXED_PRIO_EN (lowest index always wins,
// no rotating pointer). Undefined: round-robin starting from requester 0.
// Ports:
//   i_clk     : clock
//   i_reset_n : asynchronous active-low reset
//   bus       : template_arbiter_if.slave (request, datapath and response signals)
// One transaction is in flight at a time: IDLE grants, BUSY waits LAT+1 edges
// for the datapath, RESP holds the result until the consumer takes it.
module template_arbiter
    import template_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int DW   = 8,
    parameter int LAT  = 1
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    template_arbiter_if.slave  bus
);

    localparam int IDW = id_w(NREQ);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [DW-1:0]      dp_data_q;
    logic               dp_valid_q;
    logic               rsp_valid_q;
    logic [IDW-1:0]     rsp_id_q;
    logic [DW-1:0]      rsp_data_q;

    logic [NREQ-1:0]    pick_grant;
    logic [IDW-1:0]     pick_idx;
    logic               pick_any;
    logic [IDW-1:0]     pick_ptr;
    logic [NREQ-1:0]    req_ready;

    template_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .valid (bus.i_req_valid),
        .ptr   (pick_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

`ifdef TEMPLATE_ARB_FIXED_PRIO_EN
    assign pick_ptr = '0;
`else
    logic [IDW-1:0] rr_ptr_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rr_ptr_q <= '0;
        end else if (state_q == IDLE && pick_any) begin
            rr_ptr_q <= (int'(pick_idx) == NREQ - 1) ? '0 : pick_idx + 1'b1;
        end
    end

    assign pick_ptr = rr_ptr_q;
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The grant only ever covers valid requesters, so pick_any in IDLE is the transfer.
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                req_ready = pick_grant;
                if (pick_any) state_d = BUSY;
            end
            BUSY: begin
                if (!dp_valid_q && cnt_q == CNT_W'(1)) state_d = RESP;
            end
            RESP: begin
                if (bus.i_rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The first BUSY cycle is the issue cycle and does not count down, so the
    // result is captured LAT+1 edges after the transfer edge.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_q       <= '0;
            dp_data_q   <= '0;
            dp_valid_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            dp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        dp_data_q  <= bus.i_req_data[int'(pick_idx) * DW +: DW];
                        dp_valid_q <= 1'b1;
                        rsp_id_q   <= pick_idx;
                        cnt_q      <= CNT_W'(LAT);
                    end
                end
                BUSY: begin
                    if (!dp_valid_q) begin
                        if (cnt_q == CNT_W'(1)) begin
                            rsp_data_q  <= bus.i_dp_data;
                            rsp_valid_q <= 1'b1;
                            cnt_q       <= '0;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (bus.i_rsp_ready) rsp_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Ready is masked by reset so nothing can look accepted while reset is held.
    assign bus.o_req_ready = i_reset_n ? req_ready : '0;
    assign bus.o_dp_data   = dp_data_q;
    assign bus.o_dp_valid  = dp_valid_q;
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_id    = rsp_id_q;
    assign bus.o_rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_template_arbiter.sv
// tb/tb_template_arbiter.sv - directed self-checking bench for template_arbiter (LAT=1 and LAT=3)
module tb_template_arbiter;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    logic [7:0] age1;
    logic [7:0] age3;

    template_arbiter_if #(.NREQ(4), .DW(8)) b1 ();
    template_arbiter_if #(.NREQ(4), .DW(8)) b3 ();

    template_arbiter #(.NREQ(4), .DW(8), .LAT(1)) u1 (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (b1)
    );

    template_arbiter #(.NREQ(4), .DW(8), .LAT(3)) u3 (
        .i_clk     (clk),
        .i_reset_n (rst_n),
        .bus       (b3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath models: result = ~operand, presented only on the cycle the
    // arbiter is due to sample it (LAT cycles after the issue cycle).
    always @(posedge clk) begin
        age1 <= b1.o_dp_valid ? 8'd1 : age1 + 8'd1;
        age3 <= b3.o_dp_valid ? 8'd1 : age3 + 8'd1;
    end
    assign b1.i_dp_data = (age1 == 8'd1) ? ~b1.o_dp_data : 8'hC3;
    assign b3.i_dp_data = (age3 == 8'd3) ? ~b3.o_dp_data : 8'hC3;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        age1  = 8'd0;
        age3  = 8'd0;
        rst_n = 1'b0;
        b1.i_req_valid = 4'hF;
        b1.i_req_data  = 32'h0;
        b1.i_rsp_ready = 1'b0;
        b3.i_req_valid = 4'h0;
        b3.i_req_data  = 32'h0;
        b3.i_rsp_ready = 1'b1;

        // Reset state, with every requester valid.
        tick();
        tick();
        chk("reset_ready", b1.o_req_ready, 4'h0);
        chk("reset_outs", {b1.o_dp_valid, b1.o_dp_data, b1.o_rsp_valid, b1.o_rsp_id, b1.o_rsp_data}, 0);
        b1.i_req_valid = 4'h0;
        rst_n = 1'b1;
        tick();

        // Single request from requester 2, data 0x5A.
        b1.i_req_valid = 4'b0100;
        b1.i_req_data  = 32'h005A_0000;
        #1;
        chk("single_ready", b1.o_req_ready, 4'b0100);
        tick();
        b1.i_req_valid = 4'h0;
        #1;
        chk("single_issue", {b1.o_dp_valid, b1.o_dp_data, b1.o_rsp_valid}, {1'b1, 8'h5A, 1'b0});
        chk("single_busy_ready", b1.o_req_ready, 4'h0);
        tick();
        chk("single_t1", {b1.o_dp_valid, b1.o_dp_data, b1.o_rsp_valid}, {1'b0, 8'h5A, 1'b0});
        tick();
        chk("single_rsp", {b1.o_rsp_valid, b1.o_rsp_id, b1.o_rsp_data}, {1'b1, 2'd2, 8'hA5});
        b1.i_rsp_ready = 1'b1;
        tick();
        chk("single_done", b1.o_rsp_valid, 1'b0);

        // Reset held for one cycle during BUSY (requester 3 in flight).
        b1.i_req_valid = 4'b1000;
        b1.i_req_data  = 32'h3300_0000;
        tick();
        b1.i_req_valid = 4'h0;
        #1;
        chk("rst_busy_issue", {b1.o_dp_valid, b1.o_dp_data}, {1'b1, 8'h33});
        rst_n = 1'b0;
        #1;
        chk("rst_busy_outs", {b1.o_dp_valid, b1.o_dp_data, b1.o_rsp_valid, b1.o_rsp_id, b1.o_rsp_data}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        chk("rst_busy_norsp", b1.o_rsp_valid, 1'b0);

        b1.i_req_data = 32'h1312_1110;
`ifdef TEMPLATE_ARB_FIXED_PRIO_EN
        // Requesters 1 and 3 always valid: 1 wins every time.
        b1.i_req_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("fixed_ready_%0d", k), b1.o_req_ready, 4'b0010);
            tick();
            chk($sformatf("fixed_issue_%0d", k), b1.o_dp_data, 8'h11);
            tick();
            tick();
            chk($sformatf("fixed_rsp_%0d", k), {b1.o_rsp_valid, b1.o_rsp_id}, {1'b1, 2'd1});
            tick();
        end
        b1.i_req_valid = 4'h0;
`else
        // All four valid, consumer always ready: grants 0,1,2,3,0 every 4 cycles.
        b1.i_req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("rr_ready_%0d", k), b1.o_req_ready, 4'b0001 << (k % 4));
            tick();
            chk($sformatf("rr_issue_%0d", k), {b1.o_dp_valid, b1.o_dp_data}, {1'b1, 8'h10 + 8'(k % 4)});
            tick();
            chk($sformatf("rr_busy_ready_%0d", k), b1.o_req_ready, 4'h0);
            tick();
            chk($sformatf("rr_rsp_%0d", k), {b1.o_rsp_valid, b1.o_rsp_id, b1.o_rsp_data},
                {1'b1, 2'(k % 4), ~(8'h10 + 8'(k % 4))});
            tick();
        end
        b1.i_req_valid = 4'h0;
`endif

        // Backpressure: requester 1 (data 0x77), consumer stalls 5 cycles in RESP.
        tick();
        b1.i_rsp_ready = 1'b0;
        b1.i_req_valid = 4'b0010;
        b1.i_req_data  = 32'h4433_7711;
        tick();
        b1.i_req_valid = 4'hF;
        tick();
        tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_hold_%0d", k), {b1.o_rsp_valid, b1.o_rsp_id, b1.o_rsp_data, b1.o_req_ready},
                {1'b1, 2'd1, 8'h88, 4'h0});
            tick();
        end
        b1.i_rsp_ready = 1'b1;
        tick();
        chk("bp_done", b1.o_rsp_valid, 1'b0);
`ifdef TEMPLATE_ARB_FIXED_PRIO_EN
        chk("bp_next_ready", b1.o_req_ready, 4'b0001);
`else
        chk("bp_next_ready", b1.o_req_ready, 4'b0100);
`endif
        b1.i_req_valid = 4'h0;
        tick();

        // LAT=3: requester 0 held valid with 0x11; result taken 4 edges after
        // transfer, next issue 6 edges after transfer.
        b3.i_req_valid = 4'b0001;
        b3.i_req_data  = 32'h0000_0011;
        #1;
        chk("lat3_ready", b3.o_req_ready, 4'b0001);
        tick();
        chk("lat3_issue", {b3.o_dp_valid, b3.o_dp_data}, {1'b1, 8'h11});
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk($sformatf("lat3_t%0d", i), {b3.o_dp_valid, b3.o_rsp_valid},
                {(i == 6) ? 1'b1 : 1'b0, (i == 4) ? 1'b1 : 1'b0});
            if (i == 4) chk("lat3_rsp_data", {b3.o_rsp_id, b3.o_rsp_data}, {2'd0, 8'hEE});
        end
        b3.i_req_valid = 4'h0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
